// File: rtl/runner_pkg.sv
// Shared types and constants for the side-scrolling runner game core.
package runner_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_DEAD   = 2'd3
  } runner_state_t;

  // {R[1:0],G[1:0],B[1:0]}
  localparam logic [5:0] BLACK = 6'b000000;
  localparam logic [5:0] WHITE = 6'b111111;
  localparam logic [5:0] RED   = 6'b110000;
  localparam logic [5:0] GREEN = 6'b001100;

  localparam int FLOOR_H = 10;

endpackage

// File: rtl/runner_jump_physics.sv
// Player jump FSM: height above the floor and vertical velocity, stepped once per frame tick.
module runner_jump_physics
  import runner_pkg::*;
#(
  parameter int JUMP_V0 = 12,
  parameter int GRAVITY = 1,
  parameter int MAX_H   = 310
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          jump_s,
  input  logic          collide,
  input  logic          restart,
  output logic [9:0]    height,
  output logic          dead,
  output runner_state_t state
);

  localparam logic signed [11:0] V0   = 12'(JUMP_V0);
  localparam logic signed [11:0] G    = 12'(GRAVITY);
  localparam logic        [11:0] HMAX = 12'(MAX_H);

  logic signed [11:0] vel;
  logic signed [11:0] vel_rise;
  logic signed [11:0] vel_fall;
  logic        [11:0] h_sum;
  logic        [11:0] h_rise;
  logic        [11:0] h_fall;

  // Rising height is clamped so the player box never leaves the top of the screen.
  always_comb begin
    vel_rise = vel - G;
    vel_fall = vel + G;
    h_sum    = {2'b00, height} + $unsigned(vel);
    h_rise   = (h_sum > HMAX) ? HMAX : h_sum;
    h_fall   = ({2'b00, height} > $unsigned(vel_fall)) ?
               ({2'b00, height} - $unsigned(vel_fall)) : 12'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_GROUND;
      height <= '0;
      vel    <= '0;
      dead   <= 1'b0;
    end else if (state == ST_DEAD) begin
      if (restart) begin
        state  <= ST_GROUND;
        height <= '0;
        vel    <= '0;
        dead   <= 1'b0;
      end
    end else if (tick) begin
      if (collide) begin
        state <= ST_DEAD;
        dead  <= 1'b1;
      end else begin
        case (state)
          ST_GROUND: begin
            if (jump_s) begin
              state <= ST_RISE;
              vel   <= V0;
            end
          end
          ST_RISE: begin
            height <= h_rise[9:0];
            if (vel_rise <= 12'sd0) begin
              state <= ST_FALL;
              vel   <= '0;
            end else begin
              vel <= vel_rise;
            end
          end
          ST_FALL: begin
            height <= h_fall[9:0];
            if (h_fall == 12'd0) begin
              state <= ST_GROUND;
              vel   <= '0;
            end else begin
              vel <= vel_fall;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/runner_game_core.sv
// Runner game core: button sync, scrolling obstacles, score, collision and per-pixel drawing.
module runner_game_core
  import runner_pkg::*;
#(
  parameter int GROUND_Y     = 330,
  parameter int PLAYER_X     = 310,
  parameter int PLAYER_W     = 20,
  parameter int PLAYER_H     = 20,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1,
  parameter int OBST_PERIOD  = 64,
  parameter int OBST_W       = 10,
  parameter int OBST_H       = 15,
  parameter int SCROLL_SPEED = 2,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic               video_active,
  input  logic               jump_btn,
  input  logic               restart_btn,
  output logic [5:0]         rgb,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int SCR_W = $clog2(OBST_PERIOD);
  localparam logic [10:0]    GY    = 11'(GROUND_Y);
  localparam logic [10:0]    PX    = 11'(PLAYER_X);
  localparam logic [10:0]    PW    = 11'(PLAYER_W);
  localparam logic [10:0]    PH    = 11'(PLAYER_H);
  localparam logic [10:0]    OP    = 11'(OBST_PERIOD);
  localparam logic [10:0]    OW    = 11'(OBST_W);
  localparam logic [10:0]    OH    = 11'(OBST_H);
  localparam logic [10:0]    FH    = 11'(FLOOR_H);
  localparam logic [SCR_W:0] SPEED = (SCR_W+1)'(SCROLL_SPEED);

  logic jump_meta, jump_s;
  logic rbtn_meta, rbtn_sync, rbtn_prev;
  logic restart;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      jump_meta <= 1'b0;
      jump_s    <= 1'b0;
      rbtn_meta <= 1'b0;
      rbtn_sync <= 1'b0;
      rbtn_prev <= 1'b0;
    end else begin
      jump_meta <= jump_btn;
      jump_s    <= jump_meta;
      rbtn_meta <= restart_btn;
      rbtn_sync <= rbtn_meta;
      rbtn_prev <= rbtn_sync;
    end
  end

  assign restart = rbtn_sync & ~rbtn_prev;

  logic [9:0]    height;
  logic          dead;
  logic          collide;
  runner_state_t phys_state;

  runner_jump_physics #(
    .JUMP_V0 (JUMP_V0),
    .GRAVITY (GRAVITY),
    .MAX_H   (GROUND_Y - PLAYER_H)
  ) u_phys (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (frame_tick),
    .jump_s  (jump_s),
    .collide (collide),
    .restart (restart),
    .height  (height),
    .dead    (dead),
    .state   (phys_state)
  );

  assign game_over = (phys_state == ST_DEAD);

  logic [SCR_W-1:0] scroll;
  logic [SCR_W:0]   scroll_sum;
  logic [10:0]      px, py, p_top, p_bot, ob_col;
  logic             in_player, in_obst, in_floor;
  logic [5:0]       colour;

  always_comb begin
    scroll_sum = {1'b0, scroll} + SPEED;
    px         = {1'b0, pix_x};
    py         = {1'b0, pix_y};
    p_bot      = GY - {1'b0, height};
    p_top      = p_bot - PH;
    ob_col     = (px + {{(11-SCR_W){1'b0}}, scroll}) & (OP - 11'd1);
    in_player  = (px >= PX) && (px < PX + PW) && (py >= p_top) && (py < p_bot);
    in_obst    = (ob_col >= OP - OW) && (py >= GY - OH) && (py < GY);
    in_floor   = (py >= GY) && (py <= GY + FH);
    colour     = BLACK;
    if (in_player)     colour = dead ? RED : GREEN;
    else if (in_obst)  colour = RED;
    else if (in_floor) colour = WHITE;
  end

  // A tick that finds a pending collision freezes the whole game at that frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scroll  <= '0;
      score   <= '0;
      collide <= 1'b0;
      rgb     <= BLACK;
    end else begin
      rgb <= video_active ? colour : BLACK;
      if (dead && restart) begin
        scroll  <= '0;
        score   <= '0;
        collide <= 1'b0;
      end else if (frame_tick && !dead) begin
        if (!collide) begin
          scroll <= scroll_sum[SCR_W-1:0];
          if (scroll_sum[SCR_W] && (score != {SCORE_W{1'b1}}))
            score <= score + SCORE_W'(1);
        end
        collide <= 1'b0;
      end else if (video_active && in_player && in_obst) begin
        collide <= 1'b1;
      end
    end
  end

endmodule
